// File: rtl/vga_clut_scanout.sv
// Palette-indexed VGA scanout engine in the pixel clock domain.
// Raster timing, double-buffered linear framebuffer addressing, 256-entry CLUT
// lookup, cross-hair cursor overlay and aligned RGB/sync/blank outputs.
module vga_clut_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19,
  parameter int IDX_W    = 8,
  parameter int CH_W     = 10,
  parameter int RD_LAT   = 2
) (
  input  logic              NCLK_n,
  input  logic              avs_s1_reset_n_iRST_N,
  input  logic [ADDR_W-1:0] iFB_BASE0,
  input  logic [ADDR_W-1:0] iFB_BASE1,
  input  logic              iFlip_req,
  output logic              oFlip_ack,
  output logic              oActive_buf,
  output logic [ADDR_W-1:0] oFB_ADDR,
  output logic              oFB_RD,
  input  logic [IDX_W-1:0]  iFB_INDEX,
  output logic [IDX_W-1:0]  oCLUT_ADDR,
  input  logic [23:0]       iCLUT_BGR,
  input  logic [2:0]        iCursor_EN,
  input  logic [9:0]        iCursor_X,
  input  logic [9:0]        iCursor_Y,
  input  logic [CH_W-1:0]   iCursor_R,
  input  logic [CH_W-1:0]   iCursor_G,
  input  logic [CH_W-1:0]   iCursor_B,
  output logic [CH_W-1:0]   oVGA_R,
  output logic [CH_W-1:0]   oVGA_G,
  output logic [CH_W-1:0]   oVGA_B,
  output logic              oVGA_HS,
  output logic              oVGA_VS,
  output logic              oVGA_BLANK_N,
  output logic              oVGA_SYNC_N,
  output logic              oFrame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  // Side-band pipe: index 0 is the address stage, OUT the stage whose CLUT
  // data is on iCLUT_BGR and gets registered onto the outputs.
  localparam int DEPTH   = RD_LAT + 3;
  localparam int OUT     = DEPTH - 1;

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [31:0]       hWide;
  logic [31:0]       vWide;
  logic              lineEnd;
  logic              frameEnd;
  logic              frameTop;
  logic              flipPoint;
  logic              active;
  logic              hsN;
  logic              vsN;
  logic              cursorHit;
  logic              activeBuf;
  logic [ADDR_W-1:0] addrCnt;
  logic [ADDR_W-1:0] addrCur;
  logic [DEPTH-1:0]  actPipe;
  logic [DEPTH-1:0]  hsPipe;
  logic [DEPTH-1:0]  vsPipe;
  logic [DEPTH-1:0]  hitPipe;

  function automatic logic [CH_W-1:0] expandCh(input logic [7:0] b);
    logic [CH_W-1:0] c;
    c = '0;
    c[CH_W-1 -: 8] = b;
    return c;
  endfunction

  assign oActive_buf  = activeBuf;
  assign oFB_RD       = actPipe[0];
  assign oVGA_SYNC_N  = 1'b0;
  assign oFrame_start = avs_s1_reset_n_iRST_N && frameTop;

  // Decode raster position into timing flags, cursor hit and pixel address.
  // The base is muxed in combinationally at the frame origin instead of being
  // loaded into the counter, so no multiplier or async load is needed.
  always_comb begin
    hWide     = 32'(h);
    vWide     = 32'(v);
    lineEnd   = (hWide == H_TOTAL - 1);
    frameEnd  = lineEnd && (vWide == V_TOTAL - 1);
    frameTop  = (hWide == 0) && (vWide == 0);
    flipPoint = (hWide == 0) && (vWide == V_ACTIVE + V_FP);
    active    = (hWide < H_ACTIVE) && (vWide < V_ACTIVE);
    hsN       = !((hWide >= H_ACTIVE + H_FP) && (hWide < H_ACTIVE + H_FP + H_SYNC));
    vsN       = !((vWide >= V_ACTIVE + V_FP) && (vWide < V_ACTIVE + V_FP + V_SYNC));
    cursorHit = active && ((hWide == 32'(iCursor_X)) || (vWide == 32'(iCursor_Y)));
    addrCur   = frameTop ? (activeBuf ? iFB_BASE1 : iFB_BASE0) : addrCnt;
  end

  // Horizontal and vertical raster counters.
  always_ff @(posedge NCLK_n or negedge avs_s1_reset_n_iRST_N) begin
    if (!avs_s1_reset_n_iRST_N) begin
      h <= '0;
      v <= '0;
    end else if (lineEnd) begin
      h <= '0;
      v <= frameEnd ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // Linear address counter and page-flip handshake at the start of vsync.
  always_ff @(posedge NCLK_n or negedge avs_s1_reset_n_iRST_N) begin
    if (!avs_s1_reset_n_iRST_N) begin
      addrCnt   <= '0;
      activeBuf <= 1'b0;
      oFlip_ack <= 1'b0;
    end else begin
      addrCnt   <= addrCur + ADDR_W'(active);
      oFlip_ack <= flipPoint && iFlip_req;
      if (flipPoint && iFlip_req) begin
        activeBuf <= !activeBuf;
      end
    end
  end

  // Address stage plus side-band delay lines that keep sync/blank/cursor aligned.
  always_ff @(posedge NCLK_n or negedge avs_s1_reset_n_iRST_N) begin
    if (!avs_s1_reset_n_iRST_N) begin
      oFB_ADDR <= '0;
      actPipe  <= '0;
      hsPipe   <= '1;
      vsPipe   <= '1;
      hitPipe  <= '0;
    end else begin
      oFB_ADDR <= addrCur;
      actPipe  <= {actPipe[DEPTH-2:0], active};
      hsPipe   <= {hsPipe[DEPTH-2:0], hsN};
      vsPipe   <= {vsPipe[DEPTH-2:0], vsN};
      hitPipe  <= {hitPipe[DEPTH-2:0], cursorHit};
    end
  end

  // Register the framebuffer index onto the palette address.
  always_ff @(posedge NCLK_n or negedge avs_s1_reset_n_iRST_N) begin
    if (!avs_s1_reset_n_iRST_N) begin
      oCLUT_ADDR <= '0;
    end else begin
      oCLUT_ADDR <= iFB_INDEX;
    end
  end

  // Cursor overlay, blanking and final output register.
  always_ff @(posedge NCLK_n or negedge avs_s1_reset_n_iRST_N) begin
    if (!avs_s1_reset_n_iRST_N) begin
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
    end else begin
      oVGA_HS      <= hsPipe[OUT];
      oVGA_VS      <= vsPipe[OUT];
      oVGA_BLANK_N <= actPipe[OUT];
      if (actPipe[OUT]) begin
        oVGA_R <= (hitPipe[OUT] && iCursor_EN[2]) ? iCursor_R : expandCh(iCLUT_BGR[7:0]);
        oVGA_G <= (hitPipe[OUT] && iCursor_EN[1]) ? iCursor_G : expandCh(iCLUT_BGR[15:8]);
        oVGA_B <= (hitPipe[OUT] && iCursor_EN[0]) ? iCursor_B : expandCh(iCLUT_BGR[23:16]);
      end else begin
        oVGA_R <= '0;
        oVGA_G <= '0;
        oVGA_B <= '0;
      end
    end
  end

endmodule

// File: doc/vga_clut_scanout.md
Name: vga_clut_scanout

Overview:
- Parametrised palette-indexed VGA scanout engine in the pixel domain.
- Generates VGA timing from generic porch/sync parameters and produces linear framebuffer read addresses from one of two selectable base addresses (double buffering).
- Performs the 256-entry CLUT lookup, overlays a cross-hair cursor with per-channel enables, and drives aligned RGB/sync/blank outputs.
- Replaces the fixed 640x480 single-buffer scanout path inside the NIOS VGA peripheral.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
ADDR_W, 19, framebuffer address width
IDX_W, 8, palette index width (CLUT depth = 2^IDX_W)
CH_W, 10, output colour channel width (must be >= 8)
RD_LAT, 2, framebuffer read latency in cycles (1..4)

Ports:
NCLK_n  in  1  pixel clock, rising edge active
avs_s1_reset_n_iRST_N  in  1  asynchronous active-low reset
iFB_BASE0  in  ADDR_W  base address of buffer 0
iFB_BASE1  in  ADDR_W  base address of buffer 1
iFlip_req  in  1  level request to swap the displayed buffer
oFlip_ack  out  1  one-cycle pulse when a flip is taken
oActive_buf  out  1  currently displayed buffer
oFB_ADDR  out  ADDR_W  framebuffer read address
oFB_RD  out  1  read strobe, high for active pixels
iFB_INDEX  in  IDX_W  framebuffer data, valid RD_LAT cycles after address
oCLUT_ADDR  out  IDX_W  palette address (registered copy of iFB_INDEX)
iCLUT_BGR  in  24  palette data {B,G,R}, valid 1 cycle after oCLUT_ADDR
iCursor_EN  in  3  per-channel cursor enable {R,G,B}
iCursor_X  in  10  cursor column
iCursor_Y  in  10  cursor row
iCursor_R / iCursor_G / iCursor_B  in  CH_W each  cursor colour
oVGA_R / oVGA_G / oVGA_B  out  CH_W each  pixel colour
oVGA_HS  out  1  horizontal sync, active low
oVGA_VS  out  1  vertical sync, active low
oVGA_BLANK_N  out  1  high during visible pixels
oVGA_SYNC_N  out  1  tied 0
oFrame_start  out  1  one-cycle pulse at h=0, v=0 (undelayed)

Behaviour:
- Reset (asynchronous) values:
  - h = 0, v = 0, address counter = iFB_BASE0 sampled at release.
  - oActive_buf = 0, oFlip_ack = 0, oFB_RD = 0, oFB_ADDR = 0, oCLUT_ADDR = 0.
  - RGB = 0, HS = 1, VS = 1, BLANK_N = 0, all pipeline valids = 0, oFrame_start = 0.
- Counters:
  - h runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. When h wraps, v increments; v runs 0..V_TOTAL-1 and wraps to 0.
  - Active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - HS is low when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - VS is low when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Address generation:
  - No multiplier. At h=0, v=0 the address counter loads the base of the displayed buffer.
  - The counter increments by 1 on each active pixel and holds during blanking.
  - oFB_ADDR/oFB_RD are registered from the counter and active flag (stage 0). Overflow wraps modulo 2^ADDR_W.
- Page flip:
  - iFlip_req is sampled on the first cycle of vertical sync only: h=0, v=V_ACTIVE+V_FP.
  - If high at that cycle: oActive_buf toggles and oFlip_ack pulses for exactly 1 cycle.
  - Requests that are held stay pending until the next sample point. A request dropped before the sample point is ignored.
  - A request held across several frames flips once per frame.
  - Base inputs are read only at frame start, so mid-frame changes to iFB_BASEx take effect on the next frame.
- Pixel pipeline (P = RD_LAT + 3 cycles, address to output):
  - Stage 0: address issued.
  - Stage RD_LAT: iFB_INDEX registered onto oCLUT_ADDR.
  - Stage RD_LAT+1: iCLUT_BGR captured.
  - Stage RD_LAT+2: cursor mux and blank, output registered.
  - Active flag, HS, VS, and cursor-hit are delayed through matching shift registers so all outputs are aligned.
- Colour conversion: channel = {byte, (CH_W-8) zero bits}. R = bits[7:0], G = [15:8], B = [23:16].
- Cursor hit: active && (h == iCursor_X || v == iCursor_Y). On a hit, each channel whose enable bit is set takes the cursor colour; other channels take the CLUT colour.
- Blanked pixels output RGB = 0 regardless of cursor or CLUT.
- Cursor coordinates outside the active area produce no hit on that axis.
- Asserting reset mid-frame aborts immediately. After release, the first output pixel appears P cycles after the first active cycle.

Test Plan:
- Reset release with default params, iFB_BASE0=0 → first oFB_RD=1 with oFB_ADDR=0; oFB_ADDR=639 at h=639; line 1 starts at 640; last frame address 307199; HS low 96 cycles per 800; VS low 2 lines per 525.
- Model memory returning index = addr[7:0], CLUT returning {8'hAA,8'h55,idx} → oVGA_R = {idx,2'b00}, G = 0x154, B = 0x2A8, each P=5 cycles after address; BLANK_N aligned.
- iFB_BASE1=0x10000, iFlip_req held 1 → flip on first VS line, ack pulse 1 cycle, next frame starts at 0x10000; request dropped at v=400 → no flip.
- iCursor_EN=3'b100, X=100, Y=50, R=0x3FF → column 100 and row 50 show R=0x3FF with G/B from CLUT; X=700 → only row 50 is marked.
- Reset asserted at h=300, v=200 → outputs go to reset values asynchronously; after release, timing restarts at h=0, v=0 and oActive_buf=0.
- Parameter set H_ACTIVE=320, V_ACTIVE=240, CH_W=8, RD_LAT=1 → P=4, last frame address 76799, output channels equal the CLUT bytes unchanged.
